// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default geometry and address-width helper for the register bank.
package reg_file_pkg;
    localparam int REG_FILE_WIDTH = 16;
    localparam int REG_FILE_DEPTH = 8;

    function automatic int reg_file_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/reg_file_entry.sv
// reg_file_entry: one loadable WIDTH-bit register with sync clear, async active-low reset
// and a valid flag set on load.
module reg_file_entry #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    // clear outranks load so a colliding write is dropped
    always_comb begin
        data_d  = clear_i ? '0 : load_i ? data_i : data_q;
        valid_d = clear_i ? 1'b0 : load_i ? 1'b1 : valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register bank, one write port, two combinational read ports.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = REG_FILE_WIDTH,
    parameter int DEPTH = REG_FILE_DEPTH,
    parameter int AW    = reg_file_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd0_addr,
    output logic [WIDTH-1:0] rd0_data,
    output logic             rd0_valid,
    input  logic [AW-1:0]    rd1_addr,
    output logic [WIDTH-1:0] rd1_data,
    output logic             rd1_valid
);
    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        reg_file_entry #(.WIDTH(WIDTH)) u_ent (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (clear),
            .load_i  (wr_en && wr_addr == AW'(i)),
            .data_i  (wr_data),
            .data_o  (ent_data[i]),
            .valid_o (ent_valid[i])
        );
    end

`ifdef REG_FILE_BYPASS_EN
    logic byp0, byp1;
    // forwarding is gated by rst_n so outputs stay 0 throughout reset
    always_comb begin
        byp0      = rst_n && wr_en && !clear && rd0_addr == wr_addr;
        byp1      = rst_n && wr_en && !clear && rd1_addr == wr_addr;
        rd0_data  = byp0 ? wr_data : ent_data[rd0_addr];
        rd0_valid = byp0 ? 1'b1 : ent_valid[rd0_addr];
        rd1_data  = byp1 ? wr_data : ent_data[rd1_addr];
        rd1_valid = byp1 ? 1'b1 : ent_valid[rd1_addr];
    end
`else
    always_comb begin
        rd0_data  = ent_data[rd0_addr];
        rd0_valid = ent_valid[rd0_addr];
        rd1_data  = ent_data[rd1_addr];
        rd1_valid = ent_valid[rd1_addr];
    end
`endif
endmodule

// File: doc/reg_file.md
# reg_file

Parametrised register bank that generalises the team's single 16-bit load register into DEPTH entries of WIDTH bits. It has one write port, two independent combinational read ports, and per-entry valid tracking. It sits between the datapath ALU and its operand sources as the CPU's general-purpose register storage. An optional same-cycle write-to-read bypass is selected at compile time.

## Interface
- WIDTH, 16, data width of each entry in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AW, $clog2(DEPTH), derived address width; not overridden by users
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous clear of all entries and valid bits
- wr_en  input  1  write enable (the "load" of the entry selected by wr_addr)
- wr_addr  input  AW  write entry index
- wr_data  input  WIDTH  write data
- rd0_addr  input  AW  read port 0 index
- rd0_data  output  WIDTH  read port 0 data
- rd0_valid  output  1  entry rd0_addr has been written since last reset/clear
- rd1_addr  input  AW  read port 1 index
- rd1_data  output  WIDTH  read port 1 data
- rd1_valid  output  1  as rd0_valid, for port 1

## Operation
- Storage: DEPTH entries of data[WIDTH] plus valid[1].
- Reset (rst_n=0): every entry data=0, valid=0, asynchronously. Outputs are therefore 0 during reset. No write can occur while rst_n=0.
- Clear (clear=1 at an edge): all entries become data=0, valid=0.
  - clear has priority over wr_en in the same cycle; that write is dropped.
- Write (wr_en=1, clear=0 at an edge): entry[wr_addr].data←wr_data and valid←1. All other entries hold.
- Without a write, every entry holds its value indefinitely, as a load register does with load=0.
- Reads are purely combinational: rdN_data=entry[rdN_addr].data and rdN_valid=entry[rdN_addr].valid.
- Both ports may address the same entry, and either may equal wr_addr. There are no conflicts and no stalls.
- Addresses are always in range, because DEPTH is a power of two.
- Reset asserted mid-cycle wins over any pending write or clear.

## Timing
- Write latency: 1 cycle. Data written at edge t is visible on a read port after edge t.
- Read latency: 0 cycles (combinational from rdN_addr and storage).
- Same-cycle read of wr_addr: the port returns the old contents (bypass excluded, see Configuration).
- Clear latency: 1 cycle. After the clear edge, all reads return 0 with valid=0.
- Reset deassertion: the first write may occur at the first rising edge with rst_n=1.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - When wr_en=1, clear=0 and rdN_addr==wr_addr, port N returns wr_data with rdN_valid=1 in the same cycle.
  - Bypass is suppressed while clear=1 or rst_n=0.
- REG_FILE_BYPASS_EN undefined: reads always reflect stored state only.
- Storage and write behaviour are identical in both builds.

## Structure
- Package reg_file_pkg contains:
  - default constants REG_FILE_WIDTH=16 and REG_FILE_DEPTH=8
  - a function computing AW
- Sub-module reg_file_entry: one WIDTH-bit register with load, sync clear, async active-low reset, and valid bit.
  - reg_file instantiates DEPTH of them via generate.
  - The write decoder drives each entry's load.
  - Two DEPTH:1 muxes form the read ports, followed by the optional bypass muxes.

## Test plan
- Reset: hold rst_n=0, then release. All 8 entries read data=0x0000 and valid=0 on both ports.
- Write/read: write 0x1234 to entry 3 and 0xBEEF to entry 7 on consecutive cycles. On the next cycle, rd0_addr=3 gives 0x1234/valid=1, rd1_addr=7 gives 0xBEEF/valid=1, and entry 5 gives 0/valid=0.
- Clear vs write: issue clear=1 and wr_en=1 (addr 2, 0xAAAA) in the same cycle. Afterwards entry 2 and all others read 0/valid=0.
- Same-cycle read of write address: rd0_addr=wr_addr=4 with wr_data=0x5555 while entry 4 holds 0x1111.
  - Without the macro, port 0 shows 0x1111 during the cycle and 0x5555 after.
  - With REG_FILE_BYPASS_EN, port 0 shows 0x5555/valid=1 during the cycle.
- Async reset mid-operation: pulse rst_n low between edges while wr_en=1. Outputs go to 0 immediately and no write lands afterwards.
- Parameter sweep: repeat the write/read scenario with WIDTH=8, DEPTH=2 and with WIDTH=32, DEPTH=32. Check the top-index entry and full-width value 0xFF / 0xFFFFFFFF.
